// File: rtl/instrument_poll_sequencer.sv
// ---------------------------------------------------------------------------
// instrument_poll_sequencer
//
// AXI4-Lite master that configures and periodically samples an instrument
// register bank. An accepted `start` writes `cfg_data` to register 0 at
// C_BASE_ADDR. It then reads C_NUM_REGS consecutive 32-bit registers into a
// shadow buffer. The whole buffer is published as one atomic snapshot on
// `snap_data`, marked by a one-cycle `snap_valid` pulse. While `enable`
// stays high the read sweep repeats. The RD_REQ entries of two consecutive
// sweeps are `period`+1 cycles apart, counted from the edge that enters DONE.
//
// Ports
//   ACLK, ARESETN      : clock, synchronous active-low reset
//   start              : pulse, begins config write + first sweep (IDLE only)
//   enable             : level, keep sweeping while high
//   period             : idle cycles between sweeps, sampled in DONE
//   cfg_data           : config word, sampled on an accepted start
//   snap_data          : snapshot, register i at [32i+31:32i]
//   snap_valid         : one-cycle pulse when snap_data updates
//   busy               : high whenever the FSM is not in IDLE
//   err                : sticky non-OKAY response flag, cleared by start
//   M_AXI_*            : AXI4-Lite master (AW, W, B, AR, R channels)
//   dbg_state          : current FSM state encoding (see state_t)
//
// Handshake semantics (every channel): a transfer happens at the rising
// edge where VALID and READY are both 1. This block's VALID outputs are
// registered. Each one rises on the edge that enters its request state and
// is never withdrawn before its transfer. It falls on the transfer edge.
// ADDR/DATA are loaded together with VALID and do not change while VALID
// is high. BREADY/RREADY are registered, high for the whole response state,
// and fall on the accepting edge. Only one transaction is outstanding at a
// time.
// ---------------------------------------------------------------------------
module instrument_poll_sequencer #(
  parameter logic [31:0] C_BASE_ADDR = 32'h0000_0000,
  parameter int          C_NUM_REGS  = 4,
  parameter int          C_PERIOD_W  = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,

  input  logic                    start,
  input  logic                    enable,
  input  logic [C_PERIOD_W-1:0]   period,
  input  logic [31:0]             cfg_data,

  output logic [32*C_NUM_REGS-1:0] snap_data,
  output logic                    snap_valid,
  output logic                    busy,
  output logic                    err,

  output logic [31:0]             M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,

  output logic [31:0]             M_AXI_WDATA,
  output logic [3:0]              M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,

  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,

  output logic [31:0]             M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,

  input  logic [31:0]             M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY,

  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_RESP = 3'd4,
    S_DONE    = 3'd5,
    S_WAIT    = 3'd6
  } state_t;

  // Index is 4 bits so that up to 16 registers can be swept.
  localparam logic [3:0] LAST_IDX = 4'(C_NUM_REGS - 1);

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_t                    r_state;
  logic [3:0]                r_idx;
  logic [C_PERIOD_W-1:0]     r_cnt;
  logic [32*C_NUM_REGS-1:0]  r_shadow;
  logic [32*C_NUM_REGS-1:0]  r_snap_data;
  logic                      r_snap_valid;
  logic                      r_err;

  logic [31:0]               r_awaddr;
  logic                      r_awvalid;
  logic [31:0]               r_wdata;
  logic                      r_wvalid;
  logic                      r_bready;
  logic [31:0]               r_araddr;
  logic                      r_arvalid;
  logic                      r_rready;

  // ---------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_b_hs;
  logic        w_ar_hs;
  logic        w_r_hs;
  logic        w_aw_done;
  logic        w_w_done;
  logic        w_last;
  logic [31:0] w_next_araddr;

  assign w_aw_hs = r_awvalid & M_AXI_AWREADY;
  assign w_w_hs  = r_wvalid  & M_AXI_WREADY;
  assign w_b_hs  = r_bready  & M_AXI_BVALID;
  assign w_ar_hs = r_arvalid & M_AXI_ARREADY;
  assign w_r_hs  = r_rready  & M_AXI_RVALID;

  // Inside WR_REQ a low VALID means that channel has already completed.
  // The AW and W handshakes may complete in either order, so each channel
  // counts as done when it completes now or has completed earlier.
  assign w_aw_done = w_aw_hs | ~r_awvalid;
  assign w_w_done  = w_w_hs  | ~r_wvalid;

  assign w_last        = (r_idx == LAST_IDX);
  assign w_next_araddr = C_BASE_ADDR + {26'd0, r_idx + 4'd1, 2'b00};

  // ---------------------------------------------------------------------
  // Sequencer FSM (all outputs registered)
  // ---------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state      <= S_IDLE;
      r_idx        <= 4'd0;
      r_cnt        <= '0;
      r_shadow     <= '0;
      r_snap_data  <= '0;
      r_snap_valid <= 1'b0;
      r_err        <= 1'b0;
      r_awaddr     <= 32'd0;
      r_awvalid    <= 1'b0;
      r_wdata      <= 32'd0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_araddr     <= 32'd0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
    end else begin
      r_snap_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_wdata   <= cfg_data;
            r_awaddr  <= C_BASE_ADDR;
            r_err     <= 1'b0;
            r_idx     <= 4'd0;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= S_WR_REQ;
          end
        end

        S_WR_REQ: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end

        S_WR_RESP: begin
          if (w_b_hs) begin
            r_err     <= r_err | (M_AXI_BRESP != 2'b00);
            r_bready  <= 1'b0;
            r_idx     <= 4'd0;
            r_araddr  <= C_BASE_ADDR;
            r_arvalid <= 1'b1;
            r_state   <= S_RD_REQ;
          end
        end

        S_RD_REQ: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_RESP;
          end
        end

        S_RD_RESP: begin
          if (w_r_hs) begin
            // Data is captured even on a non-OKAY response; only err records it.
            for (int i = 0; i < C_NUM_REGS; i++) begin
              if (r_idx == 4'(i)) r_shadow[32*i +: 32] <= M_AXI_RDATA;
            end
            r_err    <= r_err | (M_AXI_RRESP != 2'b00);
            r_rready <= 1'b0;
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_idx     <= r_idx + 4'd1;
              r_araddr  <= w_next_araddr;
              r_arvalid <= 1'b1;
              r_state   <= S_RD_REQ;
            end
          end
        end

        S_DONE: begin
          // The whole buffer moves in one edge, so the snapshot is never a
          // mix of two sweeps.
          r_snap_data  <= r_shadow;
          r_snap_valid <= 1'b1;
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (period == '0) begin
            r_idx     <= 4'd0;
            r_araddr  <= C_BASE_ADDR;
            r_arvalid <= 1'b1;
            r_state   <= S_RD_REQ;
          end else begin
            r_cnt   <= period;
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          // When the count reaches 1, the next edge enters RD_REQ. That edge
          // is period+1 edges after the edge that entered DONE.
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (r_cnt == C_PERIOD_W'(1)) begin
            r_idx     <= 4'd0;
            r_araddr  <= C_BASE_ADDR;
            r_arvalid <= 1'b1;
            r_state   <= S_RD_REQ;
          end else begin
            r_cnt <= r_cnt - C_PERIOD_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------
  assign snap_data     = r_snap_data;
  assign snap_valid    = r_snap_valid;
  assign busy          = (r_state != S_IDLE);
  assign err           = r_err;

  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

  assign dbg_state     = r_state;

endmodule

// File: tb/tb_instrument_poll_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instrument_poll_sequencer
//
// Directed bench for instrument_poll_sequencer. It contains:
//   - a responsive AXI4-Lite slave with per-channel ready delays and an
//     error-injection register index
//   - a scoreboard of expected writes, reads and snapshots, popped when the
//     DUT produces the matching handshake or snapshot
//   - protocol monitors for VALID/ADDR/DATA stability and sweep spacing
// ---------------------------------------------------------------------------
module tb_instrument_poll_sequencer;

  localparam int          NR   = 4;
  localparam int          PW   = 16;
  localparam logic [31:0] BASE = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic              start = 1'b0;
  logic              enable = 1'b0;
  logic [PW-1:0]     period = '0;
  logic [31:0]       cfg_data = '0;
  logic [32*NR-1:0]  snap_data;
  logic              snap_valid, busy, err;
  logic [31:0]       AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]        AWPROT, ARPROT, dbg_state;
  logic [3:0]        WSTRB;
  logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic              ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]        BRESP, RRESP;

  instrument_poll_sequencer #(
    .C_BASE_ADDR(BASE), .C_NUM_REGS(NR), .C_PERIOD_W(PW)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .start(start), .enable(enable), .period(period), .cfg_data(cfg_data),
    .snap_data(snap_data), .snap_valid(snap_valid), .busy(busy), .err(err),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID),
    .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID),
    .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID),
    .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID),
    .M_AXI_RREADY(RREADY),
    .dbg_state(dbg_state)
  );

  // ---------------- slave model ----------------
  logic [31:0] regs [NR];
  int aw_delay = 0, w_delay = 0, ar_delay = 0, err_idx = 99;
  int aw_cnt, w_cnt, ar_cnt;
  bit aw_seen, w_seen;

  always @(posedge ACLK) begin
    if (!ARESETN) begin
      AWREADY <= 1'b0; WREADY <= 1'b0; BVALID <= 1'b0; BRESP <= 2'b00;
      ARREADY <= 1'b0; RVALID <= 1'b0; RDATA <= '0; RRESP <= 2'b00;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; aw_seen <= 1'b0; w_seen <= 1'b0;
    end else begin
      if (AWREADY) begin
        AWREADY <= 1'b0; aw_cnt <= 0;
        if (AWVALID) aw_seen <= 1'b1;
      end else if (AWVALID) begin
        if (aw_cnt >= aw_delay) AWREADY <= 1'b1; else aw_cnt <= aw_cnt + 1;
      end
      if (WREADY) begin
        WREADY <= 1'b0; w_cnt <= 0;
        if (WVALID) w_seen <= 1'b1;
      end else if (WVALID) begin
        if (w_cnt >= w_delay) WREADY <= 1'b1; else w_cnt <= w_cnt + 1;
      end
      if (BVALID) begin
        if (BREADY) BVALID <= 1'b0;
      end else if (aw_seen && w_seen) begin
        BVALID <= 1'b1; BRESP <= 2'b00; aw_seen <= 1'b0; w_seen <= 1'b0;
      end
      if (RVALID && RREADY) RVALID <= 1'b0;
      if (ARREADY) begin
        ARREADY <= 1'b0; ar_cnt <= 0;
        if (ARVALID) begin
          RVALID <= 1'b1;
          RDATA  <= regs[ARADDR[3:2]];
          RRESP  <= (int'(ARADDR[5:2]) == err_idx) ? 2'b10 : 2'b00;
        end
      end else if (ARVALID && !RVALID) begin
        if (ar_cnt >= ar_delay) ARREADY <= 1'b1; else ar_cnt <= ar_cnt + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [63:0]      exp_wr_q[$];
  logic [31:0]      exp_ar_q[$];
  logic [32*NR-1:0] exp_snap_q[$];
  int n_cmp = 0, n_fail = 0;
  int b_count = 0, snap_cnt = 0;
  bit spacing_on = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_write(input logic [31:0] c);
    exp_wr_q.push_back({BASE, c});
  endtask

  task automatic push_sweep();
    for (int i = 0; i < NR; i++) exp_ar_q.push_back(BASE + 32'(4 * i));
    exp_snap_q.push_back({regs[3], regs[2], regs[1], regs[0]});
  endtask

  // ---------------- monitors ----------------
  logic [31:0] cap_awaddr, cap_wdata;
  logic        p_rst = 1'b0, p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0;
  logic        p_arv = 1'b0, p_arr = 1'b0;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [2:0]  p_state = 3'd0;
  int          done_cyc = 0;

  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (AWVALID && AWREADY) cap_awaddr = AWADDR;
      if (WVALID && WREADY) cap_wdata = WDATA;
      if (BVALID && BREADY) begin
        b_count++;
        if (exp_wr_q.size() == 0) chk("wr_unexpected", 1'(BVALID && BREADY), 0);
        else chk("wr_addr_data", {cap_awaddr, cap_wdata}, exp_wr_q.pop_front());
      end
      if (ARVALID && ARREADY) begin
        if (exp_ar_q.size() == 0) chk("ar_unexpected", 1'(ARVALID && ARREADY), 0);
        else chk("ar_addr", ARADDR, exp_ar_q.pop_front());
      end
      if (snap_valid) begin
        snap_cnt++;
        if (exp_snap_q.size() == 0) chk("snap_unexpected", snap_valid, 0);
        else chk("snap_data", snap_data, exp_snap_q.pop_front());
      end
      if (p_rst && p_awv && !p_awr) chk("aw_hold", {AWVALID, AWADDR}, {1'b1, p_awaddr});
      if (p_rst && p_wv && !p_wr) chk("w_hold", {WVALID, WDATA}, {1'b1, p_wdata});
      if (p_rst && p_arv && !p_arr) chk("ar_hold", {ARVALID, ARADDR}, {1'b1, p_araddr});
      if (dbg_state == 3'd5) done_cyc = cyc;
      if (spacing_on && dbg_state == 3'd3 && (p_state == 3'd5 || p_state == 3'd6))
        chk("sweep_spacing", cyc - done_cyc, int'(period) + 1);
    end
    p_rst = ARESETN;
    p_awv = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR;
    p_wv = WVALID; p_wr = WREADY; p_wdata = WDATA;
    p_arv = ARVALID; p_arr = ARREADY; p_araddr = ARADDR;
    p_state = dbg_state;
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [31:0] c);
    start = 1'b1; cfg_data = c;
    @(negedge ACLK);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 400) begin @(negedge ACLK); n++; end
    chk(tag, busy, 0);
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n = 0;
    while (dbg_state != s && n < 200) begin @(negedge ACLK); n++; end
    chk(tag, dbg_state, s);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_state"}, dbg_state, 0);
    chk({p, "_flags"}, {busy, err, snap_valid}, 0);
    chk({p, "_handshake"}, {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
    chk({p, "_addr_data"}, {AWADDR, WDATA, ARADDR}, 0);
    chk({p, "_snap"}, snap_data, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int b0, s0, pulses, n, arv;
    logic [31:0] c;

    regs[0] = 32'd1; regs[1] = 32'd2; regs[2] = 32'd3; regs[3] = 32'd4;
    repeat (3) @(negedge ACLK);
    chk_reset("reset");
    ARESETN = 1'b1;
    @(negedge ACLK);

    // 1: config write then a single sweep
    b0 = b_count; s0 = snap_cnt;
    push_write(32'h1); push_sweep();
    do_start(32'h1);
    wait_idle("t1_idle");
    @(negedge ACLK);
    chk("t1_err", err, 0);
    chk("t1_snaps", snap_cnt - s0, 1);
    chk("t1_writes", b_count - b0, 1);
    chk("t1_snap_value", snap_data, 128'h00000004_00000003_00000002_00000001);

    // 2: AW/W skew, WREADY three cycles after AWREADY
    w_delay = 3; b0 = b_count;
    push_write(32'h1); push_sweep();
    do_start(32'h1);
    n = 0;
    while (!(AWVALID && AWREADY) && n < 20) begin @(negedge ACLK); n++; end
    chk("t2_aw_handshake", 1'(AWVALID && AWREADY), 1);
    @(negedge ACLK);
    chk("t2_awvalid_dropped", AWVALID, 0);
    chk("t2_wvalid_held", WVALID, 1);
    wait_idle("t2_idle");
    @(negedge ACLK);
    chk("t2_one_b", b_count - b0, 1);
    chk("t2_wdata", WDATA, 32'h1);
    w_delay = 0;

    // 3: periodic sweeps, period 10, drop enable during WAIT
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    c = $urandom;
    enable = 1'b1; period = 16'd10; spacing_on = 1'b1;
    push_write(c);
    for (int k = 0; k < 3; k++) push_sweep();
    do_start(c);
    pulses = 0; n = 0;
    while (pulses < 3 && n < 600) begin
      @(negedge ACLK); n++;
      if (snap_valid) pulses++;
    end
    chk("t3_pulses", pulses, 3);
    chk("t3_in_wait", dbg_state, 6);
    enable = 1'b0;
    @(negedge ACLK);
    chk("t3_idle_next", dbg_state, 0);
    chk("t3_busy_low", busy, 0);
    arv = 0;
    repeat (30) begin @(negedge ACLK); if (ARVALID) arv++; end
    chk("t3_no_arvalid", arv, 0);
    spacing_on = 1'b0;

    // 4: error response on register 2, sticky until next start
    for (int i = 0; i < NR; i++) regs[i] = $urandom_range(32'hFFFF, 0);
    err_idx = 2; s0 = snap_cnt;
    c = $urandom;
    push_write(c); push_sweep();
    do_start(c);
    wait_idle("t4_idle");
    @(negedge ACLK);
    chk("t4_err_set", err, 1);
    chk("t4_snap_done", snap_cnt - s0, 1);
    repeat (10) @(negedge ACLK);
    chk("t4_err_sticky", err, 1);
    err_idx = 99;
    push_write(32'h1); push_sweep();
    do_start(32'h1);
    chk("t4_err_cleared", err, 0);
    chk("t4_busy", busy, 1);
    wait_idle("t4_idle2");
    @(negedge ACLK);
    chk("t4_err_stays_clear", err, 0);

    // 5: AR backpressure, then reset during RD_RESP together with start
    ar_delay = 5; s0 = snap_cnt;
    c = $urandom;
    push_write(c);
    exp_ar_q.push_back(BASE);
    do_start(c);
    wait_state(3'd4, "t5_reach_rd_resp");
    ARESETN = 1'b0; start = 1'b1; cfg_data = 32'hDEAD_BEEF;
    @(negedge ACLK);
    chk_reset("t5_reset");
    start = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1; ar_delay = 0;
    repeat (20) @(negedge ACLK);
    chk("t5_no_snap", snap_cnt - s0, 0);
    chk("t5_still_idle", {busy, dbg_state}, 0);

    // 6: start while busy is ignored
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    b0 = b_count; s0 = snap_cnt;
    push_write(32'h1); push_sweep();
    do_start(32'h1);
    wait_state(3'd4, "t6_mid_sweep");
    do_start(32'hFF);
    wait_idle("t6_idle");
    @(negedge ACLK);
    chk("t6_one_write", b_count - b0, 1);
    chk("t6_cfg_kept", WDATA, 32'h1);
    chk("t6_one_snap", snap_cnt - s0, 1);

    repeat (5) @(negedge ACLK);
    chk("end_wr_q_empty", exp_wr_q.size(), 0);
    chk("end_ar_q_empty", exp_ar_q.size(), 0);
    chk("end_snap_q_empty", exp_snap_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
